// File: rtl/preimage_search_pkg.sv
// preimage_pkg: shared state encoding, default widths and the masked-match test.
package preimage_pkg;

    localparam int N_IN_DEF  = 14;
    localparam int N_OUT_DEF = 14;

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;

    // Operands are zero-extended to 64 bits so one function serves every N_OUT up to 64.
    function automatic logic masked_match(input logic [63:0] resp, input logic [63:0] target,
                                          input logic [63:0] care);
        return ((resp ^ target) & care) == 64'd0;
    endfunction

endpackage

// File: rtl/preimage_search_if.sv
// preimage_search_if: start/result handshake plus the candidate/response pair of the external function.
interface preimage_search_if #(
    parameter int N_IN  = 14,
    parameter int N_OUT = 14
) ();
    logic             start_valid;
    logic             start_ready;
    logic [N_OUT-1:0] target;
    logic [N_OUT-1:0] care;
    logic             abort;
    logic [N_IN-1:0]  cand;
    logic [N_OUT-1:0] resp;
    logic             done_valid;
    logic             done_ready;
    logic             sat;
    logic             aborted;
    logic [N_IN-1:0]  witness;
    logic [N_IN:0]    evals;

    modport slave (
        input  start_valid, target, care, abort, resp, done_ready,
        output start_ready, cand, done_valid, sat, aborted, witness, evals
    );

    modport master (
        output start_valid, target, care, abort, resp, done_ready,
        input  start_ready, cand, done_valid, sat, aborted, witness, evals
    );
endinterface

// File: rtl/preimage_search_match.sv
// preimage_match: combinational masked comparator between the function response and the target.
module preimage_match
    import preimage_pkg::*;
#(
    parameter int W = N_OUT_DEF
) (
    input  logic [W-1:0] resp,
    input  logic [W-1:0] target,
    input  logic [W-1:0] care,
    output logic         match
);
    assign match = masked_match(64'(resp), 64'(target), 64'(care));
endmodule

// File: rtl/preimage_search.sv
// preimage_search: walks candidates 0..2^N_IN-1 through an external function, one per cycle,
// until the masked response equals the target; reports witness, exhaustion or abort.
module preimage_search
    import preimage_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF
) (
    input logic clk,
    input logic rst_n,
    preimage_search_if.slave bus
);
    localparam logic [N_IN-1:0] CAND_LAST = '1;

    state_e           state_q;
    logic [N_OUT-1:0] target_q;
    logic [N_OUT-1:0] care_q;
    logic [N_IN-1:0]  cand_q;
    logic [N_IN-1:0]  witness_q;
    logic [N_IN:0]    evals_q;
    logic             sat_q;
    logic             aborted_q;
    logic             match;

    preimage_match #(.W(N_OUT)) u_match (
        .resp   (bus.resp),
        .target (target_q),
        .care   (care_q),
        .match  (match)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            target_q  <= '0;
            care_q    <= '0;
            cand_q    <= '0;
            witness_q <= '0;
            evals_q   <= '0;
            sat_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        state_q   <= SEARCH;
                        target_q  <= bus.target;
                        care_q    <= bus.care;
                        cand_q    <= '0;
                        witness_q <= '0;
                        evals_q   <= '0;
                        sat_q     <= 1'b0;
                        aborted_q <= 1'b0;
                    end
                end
                SEARCH: begin
                    // Abort wins over a match in the same cycle and does not count the candidate.
                    if (bus.abort) begin
                        state_q   <= DONE;
                        aborted_q <= 1'b1;
                    end else if (match) begin
                        state_q   <= DONE;
                        sat_q     <= 1'b1;
                        witness_q <= cand_q;
                        evals_q   <= evals_q + 1'b1;
                    end else begin
                        evals_q <= evals_q + 1'b1;
                        if (cand_q == CAND_LAST) state_q <= DONE;
                        else cand_q <= cand_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.done_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by rst_n so no request is taken while reset is still held.
    assign bus.start_ready = rst_n && (state_q == IDLE);
    assign bus.done_valid  = (state_q == DONE);
    assign bus.cand        = cand_q;
    assign bus.sat         = sat_q;
    assign bus.aborted     = aborted_q;
    assign bus.witness     = witness_q;
    assign bus.evals       = evals_q;
endmodule

// File: tb/tb_preimage_search.sv
// tb_preimage_search: directed searches against a cand ^ 14'h1555 stub with a scoreboard-driven result monitor.
module tb_preimage_search;
    typedef struct {
        logic        sat;
        logic        ab;
        logic [13:0] wit;
        logic [13:0] cand;
        logic [14:0] evals;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force0 = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_dv = 1'b0;
    exp_t sb[$];
    exp_t snap;

    preimage_search_if #(.N_IN(14), .N_OUT(14)) bus ();

    preimage_search #(.N_IN(14), .N_OUT(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.resp = force0 ? 14'h0 : (bus.cand ^ 14'h1555);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic s, input logic a, input logic [13:0] w,
                                input logic [13:0] c, input logic [14:0] e);
        exp_t r;
        r.sat = s; r.ab = a; r.wit = w; r.cand = c; r.evals = e; r.done_cyc = 0;
        return r;
    endfunction

    // Monitor: pops the scoreboard on each rising done_valid, then checks the result is held.
    always @(posedge clk) begin
        #1;
        if (bus.done_valid && !prev_dv) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(bus.done_valid), 32'd0);
            end else begin
                snap = sb.pop_front();
                chk("sat", 32'(bus.sat), 32'(snap.sat));
                chk("aborted", 32'(bus.aborted), 32'(snap.ab));
                chk("witness", 32'(bus.witness), 32'(snap.wit));
                chk("evals", 32'(bus.evals), 32'(snap.evals));
                chk("cand", 32'(bus.cand), 32'(snap.cand));
                chk("done_cycle", 32'(cyc), 32'(snap.done_cyc));
            end
        end else if (bus.done_valid) begin
            chk("hold_sat", 32'(bus.sat), 32'(snap.sat));
            chk("hold_witness", 32'(bus.witness), 32'(snap.wit));
            chk("hold_evals", 32'(bus.evals), 32'(snap.evals));
            chk("hold_cand", 32'(bus.cand), 32'(snap.cand));
        end
        prev_dv = bus.done_valid;
    end

    task automatic launch(input logic [13:0] tgt, input logic [13:0] cr, input bit push,
                          input exp_t e, input int lat);
        int n = 0;
        while (!bus.start_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("start_ready_wait", 32'(bus.start_ready), 32'd1);
        bus.start_valid = 1'b1;
        bus.target = tgt;
        bus.care = cr;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        chk("start_ready_busy", 32'(bus.start_ready), 32'd0);
        e.done_cyc = cyc + lat - 1;
        if (push) sb.push_back(e);
    endtask

    task automatic finish_wait(input int hold);
        int n = 0;
        bus.done_ready = (hold == 0);
        while (!bus.done_valid && n < 20000) begin
            @(posedge clk); #1; n++;
        end
        chk("done_wait", 32'(bus.done_valid), 32'd1);
        if (hold > 0) begin
            repeat (hold - 1) begin @(posedge clk); #1; end
            chk("done_held", 32'(bus.done_valid), 32'd1);
            bus.done_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(bus.done_valid), 32'd0);
        chk("ready_after_done", 32'(bus.start_ready), 32'd1);
    endtask

    initial begin
        bus.start_valid = 1'b0;
        bus.target = '0;
        bus.care = '0;
        bus.abort = 1'b0;
        bus.done_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", 32'(bus.start_ready), 32'd0);
        chk("rst_done_valid", 32'(bus.done_valid), 32'd0);
        chk("rst_cand", 32'(bus.cand), 32'd0);
        chk("rst_evals", 32'(bus.evals), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        launch(14'h1555, 14'h3FFF, 1'b1, mk(1, 0, 14'h0, 14'h0, 15'd1), 2);
        finish_wait(0);
        launch(14'h1554, 14'h3FFF, 1'b1, mk(1, 0, 14'h1, 14'h1, 15'd2), 3);
        finish_wait(0);
        launch(14'h0, 14'h3FFF, 1'b1, mk(1, 0, 14'h1555, 14'h1555, 15'd5462), 5463);
        finish_wait(0);
        launch(14'h3FFF, 14'h0, 1'b1, mk(1, 0, 14'h0, 14'h0, 15'd1), 2);
        finish_wait(0);

        force0 = 1'b1;
        launch(14'h1, 14'h1, 1'b1, mk(0, 0, 14'h0, 14'h3FFF, 15'd16384), 16385);
        finish_wait(0);

        launch(14'h1, 14'h1, 1'b1, mk(0, 1, 14'h0, 14'd9, 15'd9), 11);
        repeat (9) begin @(posedge clk); #1; end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        finish_wait(0);

        launch(14'h1, 14'h1, 1'b0, mk(0, 0, 14'h0, 14'h0, 15'd0), 2);
        repeat (20) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_start_ready", 32'(bus.start_ready), 32'd0);
        chk("midrst_done_valid", 32'(bus.done_valid), 32'd0);
        chk("midrst_cand", 32'(bus.cand), 32'd0);
        chk("midrst_evals", 32'(bus.evals), 32'd0);
        chk("midrst_flags", 32'({bus.sat, bus.aborted, bus.witness}), 32'd0);
        @(posedge clk); #1;
        chk("midrst_start_ready2", 32'(bus.start_ready), 32'd0);
        rst_n = 1'b1;
        force0 = 1'b0;
        @(posedge clk); #1;
        launch(14'h1554, 14'h3FFF, 1'b1, mk(1, 0, 14'h1, 14'h1, 15'd2), 3);
        finish_wait(5);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
